// File: rtl/branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_redirect_ctrl
// Description : Keeps in-flight predicted branches in program order and checks
//               each execute-stage resolution against the oldest one. On a
//               mispredict it flushes the wrong path, redirects fetch and
//               clears the queue. Every resolution produces a predictor
//               counter update.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_redirect_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pred_valid,
    input  logic                  pred_taken,
    input  logic [DATA_WIDTH-1:0] pred_pc,
    input  logic [DATA_WIDTH-1:0] pred_target,
    input  logic                  res_valid,
    input  logic                  res_taken,
    output logic                  stall_f,
    output logic                  flush,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  upd_valid,
    output logic                  upd_backward,
    output logic                  upd_correct,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                    c_AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                    c_FCW      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [c_AW:0]         c_FULL_CNT = (c_AW+1)'(DEPTH);
    localparam logic [c_FCW-1:0]      c_FLUSH_LD = c_FCW'(FLUSH_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] c_PC_STEP  = DATA_WIDTH'(4);

    typedef enum logic [0:0] {
        ST_NORMAL  = 1'b0,
        ST_RECOVER = 1'b1
    } state_t;

    state_t                r_state;
    logic [c_FCW-1:0]      r_flush_cnt;
    logic [c_AW-1:0]       r_rd_ptr;
    logic [c_AW-1:0]       r_wr_ptr;
    logic [c_AW:0]         r_count;

    logic [DATA_WIDTH-1:0] r_mem_pc    [DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_tgt   [DEPTH];
    logic                  r_mem_taken [DEPTH];

    logic                  w_normal;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_mispredict;
    logic                  w_push;
    logic [DATA_WIDTH-1:0] w_head_pc;
    logic [DATA_WIDTH-1:0] w_head_tgt;
    logic                  w_head_taken;
    logic [DATA_WIDTH-1:0] w_fix_pc;

    // Queue status, head entry and the accept/compare decisions for this cycle
    always_comb begin
        w_normal     = (r_state == ST_NORMAL);
        w_full       = (r_count == c_FULL_CNT);
        w_empty      = (r_count == '0);
        w_head_pc    = r_mem_pc[r_rd_ptr];
        w_head_tgt   = r_mem_tgt[r_rd_ptr];
        w_head_taken = r_mem_taken[r_rd_ptr];
        w_pop        = w_normal & res_valid & ~w_empty;
        w_mispredict = w_pop & (w_head_taken != res_taken);
        // full is judged before the pop; a mispredict squashes the push
        w_push       = w_normal & pred_valid & ~w_full & ~w_mispredict;
        w_fix_pc     = res_taken ? w_head_tgt : (w_head_pc + c_PC_STEP);
        stall_f      = w_full | (r_state == ST_RECOVER);
    end

    // Entry storage; contents are don't-care until written so no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]    <= pred_pc;
            r_mem_tgt[r_wr_ptr]   <= pred_target;
            r_mem_taken[r_wr_ptr] <= pred_taken;
        end
    end

    // Control FSM, queue pointers and registered pulse/sticky outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_NORMAL;
            r_flush_cnt    <= '0;
            r_rd_ptr       <= '0;
            r_wr_ptr       <= '0;
            r_count        <= '0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            upd_valid      <= 1'b0;
            upd_backward   <= 1'b0;
            upd_correct    <= 1'b0;
            overflow       <= 1'b0;
            underflow      <= 1'b0;
        end else begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            upd_valid      <= 1'b0;
            upd_backward   <= 1'b0;
            upd_correct    <= 1'b0;
            case (r_state)
                ST_NORMAL: begin
                    if (pred_valid && w_full) overflow  <= 1'b1;
                    if (res_valid && w_empty) underflow <= 1'b1;
                    if (w_pop) begin
                        upd_valid    <= 1'b1;
                        upd_backward <= (w_head_tgt < w_head_pc);
                        upd_correct  <= ~w_mispredict;
                    end
                    if (w_mispredict) begin
                        // everything younger than the head is wrong-path
                        r_rd_ptr       <= '0;
                        r_wr_ptr       <= '0;
                        r_count        <= '0;
                        flush          <= 1'b1;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= w_fix_pc;
                        r_flush_cnt    <= c_FLUSH_LD;
                        r_state        <= ST_RECOVER;
                    end else begin
                        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                        case ({w_push, w_pop})
                            2'b10:   r_count <= r_count + 1'b1;
                            2'b01:   r_count <= r_count - 1'b1;
                            default: r_count <= r_count;
                        endcase
                    end
                end
                ST_RECOVER: begin
                    // first flush cycle was entered with the counter preloaded
                    if (r_flush_cnt == '0) begin
                        flush   <= 1'b0;
                        r_state <= ST_NORMAL;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 1'b1;
                    end
                end
                default: r_state <= ST_NORMAL;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_redirect_ctrl
// Description : Directed scenarios followed by random traffic, every cycle
//               compared against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_redirect_ctrl;

    localparam int c_DEPTH = 4;
    localparam int c_FLUSH = 2;

    logic        clk;
    logic        rst_n;
    logic        pred_valid;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic [31:0] pred_target;
    logic        res_valid;
    logic        res_taken;
    logic        stall_f;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic        upd_backward;
    logic        upd_correct;
    logic        overflow;
    logic        underflow;

    branch_redirect_ctrl #(
        .DATA_WIDTH   (32),
        .DEPTH        (c_DEPTH),
        .FLUSH_CYCLES (c_FLUSH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pred_valid     (pred_valid),
        .pred_taken     (pred_taken),
        .pred_pc        (pred_pc),
        .pred_target    (pred_target),
        .res_valid      (res_valid),
        .res_taken      (res_taken),
        .stall_f        (stall_f),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .upd_valid      (upd_valid),
        .upd_backward   (upd_backward),
        .upd_correct    (upd_correct),
        .overflow       (overflow),
        .underflow      (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        taken;
    } ent_t;

    ent_t        q[$];
    int          flush_left;
    logic        e_flush, e_rv, e_uv, e_ub, e_uc, e_ovf, e_unf;
    logic [31:0] e_rpc;

    int n_checks;
    int n_fail;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        flush_left = 0;
        e_flush = 0; e_rv = 0; e_uv = 0; e_ub = 0; e_uc = 0; e_ovf = 0; e_unf = 0;
        e_rpc = '0;
    endtask

    // One clock edge of behaviour, using the inputs presented this cycle
    task automatic model_step();
        bit   full, empty;
        ent_t h;
        e_rv = 0; e_rpc = '0; e_uv = 0; e_ub = 0; e_uc = 0;
        if (flush_left > 0) begin
            flush_left--;
            e_flush = (flush_left > 0);
        end else begin
            full  = (q.size() == c_DEPTH);
            empty = (q.size() == 0);
            if (pred_valid && full) e_ovf = 1;
            if (res_valid && empty) e_unf = 1;
            if (res_valid && !empty) begin
                h    = q.pop_front();
                e_uv = 1;
                e_ub = (h.tgt < h.pc);
                if (h.taken == res_taken) begin
                    e_uc = 1;
                    if (pred_valid && !full) q.push_back('{pred_pc, pred_target, pred_taken});
                end else begin
                    e_uc       = 0;
                    e_rv       = 1;
                    e_rpc      = res_taken ? h.tgt : h.pc + 32'd4;
                    e_flush    = 1;
                    flush_left = c_FLUSH;
                    q.delete();
                end
            end else if (pred_valid && !full) begin
                q.push_back('{pred_pc, pred_target, pred_taken});
            end
        end
    endtask

    task automatic compare_all();
        check_eq("stall_f",        stall_f,        (q.size() == c_DEPTH) || (flush_left > 0));
        check_eq("flush",          flush,          e_flush);
        check_eq("redirect_valid", redirect_valid, e_rv);
        if (e_rv) check_eq("redirect_pc", redirect_pc, e_rpc);
        check_eq("upd_valid",      upd_valid,      e_uv);
        if (e_uv) begin
            check_eq("upd_backward", upd_backward, e_ub);
            check_eq("upd_correct",  upd_correct,  e_uc);
        end
        check_eq("overflow",       overflow,       e_ovf);
        check_eq("underflow",      underflow,      e_unf);
    endtask

    task automatic cycle(input logic pv, input logic pt, input logic [31:0] ppc,
                         input logic [31:0] ptg, input logic rv, input logic rt);
        pred_valid  = pv;
        pred_taken  = pt;
        pred_pc     = ppc;
        pred_target = ptg;
        res_valid   = rv;
        res_taken   = rt;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        compare_all();
    endtask

    initial begin
        logic        rt;
        logic [31:0] pc;
        n_checks = 0;
        n_fail   = 0;
        pred_valid = 0; pred_taken = 0; pred_pc = '0; pred_target = '0;
        res_valid  = 0; res_taken  = 0;
        apply_reset();

        // correct taken backward branch
        cycle(1, 1, 32'h100, 32'h80, 0, 0);
        idle();
        cycle(0, 0, 32'h0, 32'h0, 1, 1);
        check_eq("corr_upd", {28'h0, upd_valid, upd_correct, upd_backward, flush}, 32'hE);
        idle();

        // mispredict: predicted taken, actually not taken
        cycle(1, 1, 32'h200, 32'h240, 0, 0);
        cycle(1, 0, 32'h204, 32'h300, 0, 0);
        cycle(0, 0, 32'h0, 32'h0, 1, 0);
        check_eq("nt_redirect_pc", redirect_pc, 32'h204);
        check_eq("nt_flush1", {30'h0, flush, redirect_valid}, 32'h3);
        idle();
        check_eq("nt_flush2", {30'h0, flush, redirect_valid}, 32'h2);
        idle();
        check_eq("nt_flush_end", {30'h0, flush, stall_f}, 32'h0);

        // mispredict taken with same-cycle push discarded
        cycle(1, 0, 32'h10, 32'h40, 0, 0);
        cycle(1, 1, 32'h500, 32'h600, 1, 1);
        check_eq("tk_redirect_pc", redirect_pc, 32'h40);
        idle();
        idle();
        check_eq("tk_empty_stall", stall_f, 1'b0);

        // fill, overflow, drain
        for (int i = 0; i < c_DEPTH; i++) cycle(1, 0, 32'h1000 + 32'(i*4), 32'h2000, 0, 0);
        check_eq("full_stall", stall_f, 1'b1);
        cycle(1, 0, 32'h3000, 32'h3100, 0, 0);
        check_eq("full_overflow", overflow, 1'b1);
        for (int i = 0; i < c_DEPTH; i++) cycle(0, 0, 32'h0, 32'h0, 1, 0);
        check_eq("drained_stall", stall_f, 1'b0);

        // underflow, then wrap-around redirect
        cycle(0, 0, 32'h0, 32'h0, 1, 0);
        check_eq("unf_flag", underflow, 1'b1);
        check_eq("unf_no_upd", {30'h0, upd_valid, flush}, 32'h0);
        cycle(1, 1, 32'hFFFF_FFFC, 32'h10, 0, 0);
        cycle(0, 0, 32'h0, 32'h0, 1, 0);
        check_eq("wrap_redirect_pc", redirect_pc, 32'h0);
        idle();
        idle();

        // async reset in the second flush cycle
        cycle(1, 0, 32'h700, 32'h800, 0, 0);
        cycle(0, 0, 32'h0, 32'h0, 1, 1);
        idle();
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_flush_async", flush, 1'b0);
        check_eq("rst_stall_async", stall_f, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        compare_all();
        cycle(0, 0, 32'h0, 32'h0, 1, 0);
        check_eq("rst_then_empty", underflow, 1'b1);
        apply_reset();

        // random traffic
        for (int n = 0; n < 600; n++) begin
            if (q.size() > 0 && $urandom_range(3) != 0) rt = q[0].taken;
            else rt = 1'($urandom_range(1));
            pc = ($urandom_range(15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            cycle(1'($urandom_range(9) < 6), 1'($urandom_range(1)), pc,
                  $urandom() & 32'hFFFF_FFFC, 1'($urandom_range(9) < 4), rt);
            if ($urandom_range(199) == 0) apply_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
